// File: rtl/axi_beat_gen.sv
// Burst-command expander: turns one AXI (addr, len, size, burst) command into per-beat
// byte address, WSTRB lane mask and last flag. Optional 4KB-crossing reject: AXI_BEAT_GEN_4K_CHECK_EN.
module axi_beat_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [ADDR_WIDTH-1:0]     beat_addr,
    output logic [DATA_WIDTH/8-1:0]   beat_strb,
    output logic                      beat_last,
    output logic                      err_valid,
    output logic [1:0]                err_code
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(NB));
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(NB - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    typedef enum logic [1:0] {
        BT_FIXED = 2'd0,
        BT_INCR  = 2'd1,
        BT_WRAP  = 2'd2,
        BT_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SIZE  = 2'd1;
    localparam logic [1:0] ERR_BURST = 2'd2;
    localparam logic [1:0] ERR_4K    = 2'd3;

    // Byte address of beat n of a burst; all arithmetic wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] calc_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst,
        input logic [7:0]            n
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] a_al;
        logic [ADDR_WIDTH-1:0] nofs;
        logic [ADDR_WIDTH-1:0] w;
        logic [ADDR_WIDTH-1:0] wlo;
        logic [ADDR_WIDTH-1:0] res;
        step = ONE << size;
        a_al = a & ~(step - ONE);
        nofs = ADDR_WIDTH'(n) << size;
        w    = (ADDR_WIDTH'(len) + ONE) << size;
        wlo  = a & ~(w - ONE);
        case (burst)
            BT_FIXED: res = a;
            BT_WRAP:  res = wlo + ((a - wlo + nofs) & (w - ONE));
            default:  res = (n == 8'd0) ? a : a_al + nofs;
        endcase
        return res;
    endfunction

    // Lanes from the beat's own byte offset up to the end of its size-aligned container.
    function automatic logic [NB-1:0] calc_strb(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] lo;
        logic [ADDR_WIDTH-1:0] hi;
        logic [NB-1:0]         strb;
        step = ONE << size;
        lo   = addr & LANE_MASK;
        hi   = ((addr & ~(step - ONE)) & LANE_MASK) + step - ONE;
        strb = '0;
        for (int i = 0; i < NB; i++) begin
            strb[i] = (ADDR_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi);
        end
        return strb;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [2:0]            size_q, size_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
    logic [NB-1:0]         beat_strb_q, beat_strb_d;
    logic                  beat_last_q, beat_last_d;
    logic                  err_valid_q, err_valid_d;
    logic [1:0]            err_code_q, err_code_d;

    logic                  cmd_accept;
    logic                  beat_fire;
    logic [ADDR_WIDTH-1:0] cmd_lsb_mask;
    logic                  wrap_len_ok;
    logic [1:0]            err_c;
    logic [7:0]            nxt_idx;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    assign cmd_ready  = (state_q == IDLE) && !areset;
    assign beat_valid = (state_q == BURST);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign beat_fire  = beat_valid && beat_ready;

    assign cmd_lsb_mask = (ONE << cmd_size) - ONE;
    assign wrap_len_ok  = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                          (cmd_len == 8'd7) || (cmd_len == 8'd15);

    assign nxt_idx  = idx_q + 8'd1;
    assign nxt_addr = calc_addr(a_q, size_q, len_q, burst_q, nxt_idx);

`ifdef AXI_BEAT_GEN_4K_CHECK_EN
    logic page_cross_c;
    if (ADDR_WIDTH > 12) begin : g_page
        logic [ADDR_WIDTH-1:0] last_byte_c;
        assign last_byte_c = (cmd_addr & ~cmd_lsb_mask)
                           + ((ADDR_WIDTH'(cmd_len) + ONE) << cmd_size) - ONE;
        assign page_cross_c = (last_byte_c[ADDR_WIDTH-1:12] != cmd_addr[ADDR_WIDTH-1:12]);
    end else begin : g_no_page
        assign page_cross_c = 1'b0;
    end
`endif

    // Error classification; the if/else chain encodes priority size > burst > 4KB.
    always_comb begin
        err_c = ERR_NONE;
        if (cmd_size > MAX_SIZE) begin
            err_c = ERR_SIZE;
        end else if ((cmd_burst == BT_RSVD) ||
                     ((cmd_burst == BT_WRAP) &&
                      (!wrap_len_ok || ((cmd_addr & cmd_lsb_mask) != '0)))) begin
            err_c = ERR_BURST;
        end
`ifdef AXI_BEAT_GEN_4K_CHECK_EN
        else if ((cmd_burst == BT_INCR) && page_cross_c) begin
            err_c = ERR_4K;
        end
`endif
    end

    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        size_d      = size_q;
        len_d       = len_q;
        burst_d     = burst_q;
        idx_d       = idx_q;
        beat_addr_d = beat_addr_q;
        beat_strb_d = beat_strb_q;
        beat_last_d = beat_last_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (err_c != ERR_NONE) begin
                        err_valid_d = 1'b1;
                        err_code_d  = err_c;
                    end else begin
                        state_d     = BURST;
                        a_d         = cmd_addr;
                        size_d      = cmd_size;
                        len_d       = cmd_len;
                        burst_d     = cmd_burst;
                        idx_d       = 8'd0;
                        beat_addr_d = cmd_addr;
                        beat_strb_d = calc_strb(cmd_addr, cmd_size);
                        beat_last_d = (cmd_len == 8'd0);
                    end
                end
            end
            BURST: begin
                if (beat_fire) begin
                    if (beat_last_q) begin
                        state_d     = IDLE;
                        beat_last_d = 1'b0;
                    end else begin
                        idx_d       = nxt_idx;
                        beat_addr_d = nxt_addr;
                        beat_strb_d = calc_strb(nxt_addr, size_q);
                        beat_last_d = (nxt_idx == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            size_q      <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            idx_q       <= '0;
            beat_addr_q <= '0;
            beat_strb_q <= '0;
            beat_last_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            size_q      <= size_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            idx_q       <= idx_d;
            beat_addr_q <= beat_addr_d;
            beat_strb_q <= beat_strb_d;
            beat_last_q <= beat_last_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign beat_addr = beat_addr_q;
    assign beat_strb = beat_strb_q;
    assign beat_last = beat_last_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_axi_beat_gen.sv
// Directed bench for axi_beat_gen: hand-computed beat sequences, error pulses and mid-burst reset.
// Build with AXI_BEAT_GEN_4K_CHECK_EN to exercise the 4KB-crossing reject path.
module tb_axi_beat_gen;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int NB = DW / 8;

    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [1:0]    cmd_burst = '0;
    logic          beat_valid;
    logic          beat_ready = 1'b0;
    logic [AW-1:0] beat_addr;
    logic [NB-1:0] beat_strb;
    logic          beat_last;
    logic          err_valid;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi_beat_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_last  (beat_last),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves inputs scrambled afterwards so late sampling would show.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 1'b0;
        cmd_addr  = 16'hBEEF;
        cmd_len   = 8'hA5;
        cmd_size  = 3'd6;
        cmd_burst = 2'd3;
    endtask

    task automatic expect_beat(input string tag, input logic [AW-1:0] a,
                               input logic [NB-1:0] s, input logic l, input int hold);
        check({tag, "_valid"}, 32'(beat_valid), 32'd1);
        check({tag, "_addr"},  32'(beat_addr),  32'(a));
        check({tag, "_strb"},  32'(beat_strb),  32'(s));
        check({tag, "_last"},  32'(beat_last),  32'(l));
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk);
            @(negedge aclk);
            check({tag, "_hold_valid"}, 32'(beat_valid), 32'd1);
            check({tag, "_hold_addr"},  32'(beat_addr),  32'(a));
            check({tag, "_hold_strb"},  32'(beat_strb),  32'(s));
        end
        beat_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        beat_ready = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(beat_valid), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready),  32'd1);
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code);
        check({tag, "_errv"},  32'(err_valid),  32'd1);
        check({tag, "_code"},  32'(err_code),   32'(code));
        check({tag, "_nobeat"}, 32'(beat_valid), 32'd0);
        @(posedge aclk);
        @(negedge aclk);
        check({tag, "_errv_drop"}, 32'(err_valid), 32'd0);
        expect_idle({tag, "_after"});
    endtask

    initial begin
        #2;
        check("rst_beat_valid", 32'(beat_valid), 32'd0);
        check("rst_beat_addr",  32'(beat_addr),  32'd0);
        check("rst_beat_strb",  32'(beat_strb),  32'd0);
        check("rst_beat_last",  32'(beat_last),  32'd0);
        check("rst_err_valid",  32'(err_valid),  32'd0);
        check("rst_err_code",   32'(err_code),   32'd0);
        check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge aclk);

        // Unaligned INCR with 4-byte beats.
        send_cmd(16'h1003, 8'd3, 3'd2, INCR);
        expect_beat("incr_b0", 16'h1003, 8'h08, 1'b0, 0);
        expect_beat("incr_b1", 16'h1004, 8'hF0, 1'b0, 0);
        expect_beat("incr_b2", 16'h1008, 8'h0F, 1'b0, 0);
        expect_beat("incr_b3", 16'h100C, 8'hF0, 1'b1, 0);
        expect_idle("incr_end");

        // Backpressure on beat 0.
        send_cmd(16'h0005, 8'd1, 3'd3, INCR);
        expect_beat("bp_b0", 16'h0005, 8'hE0, 1'b0, 3);
        expect_beat("bp_b1", 16'h0008, 8'hFF, 1'b1, 0);
        expect_idle("bp_end");

        // WRAP, legal and misaligned.
        send_cmd(16'h0018, 8'd3, 3'd3, WRAP);
        expect_beat("wrap_b0", 16'h0018, 8'hFF, 1'b0, 0);
        expect_beat("wrap_b1", 16'h0000, 8'hFF, 1'b0, 0);
        expect_beat("wrap_b2", 16'h0008, 8'hFF, 1'b0, 0);
        expect_beat("wrap_b3", 16'h0010, 8'hFF, 1'b1, 0);
        expect_idle("wrap_end");
        send_cmd(16'h0019, 8'd3, 3'd3, WRAP);
        expect_err("wrap_misal", 2'd2);
        send_cmd(16'h0018, 8'd2, 3'd3, WRAP);
        expect_err("wrap_badlen", 2'd2);

        // FIXED repeats address and strobe.
        send_cmd(16'h0022, 8'd2, 3'd1, FIXED);
        expect_beat("fix_b0", 16'h0022, 8'h0C, 1'b0, 0);
        expect_beat("fix_b1", 16'h0022, 8'h0C, 1'b0, 0);
        expect_beat("fix_b2", 16'h0022, 8'h0C, 1'b1, 0);
        expect_idle("fix_end");

        // Illegal size / reserved burst; size error outranks the burst error.
        send_cmd(16'h0000, 8'd0, 3'd4, INCR);
        expect_err("size4", 2'd1);
        send_cmd(16'h0000, 8'd0, 3'd2, 2'd3);
        expect_err("burst3", 2'd2);
        send_cmd(16'h0000, 8'd0, 3'd5, 2'd3);
        expect_err("prio", 2'd1);

        // 4KB crossing.
        send_cmd(16'h0FFC, 8'd1, 3'd3, INCR);
`ifdef AXI_BEAT_GEN_4K_CHECK_EN
        expect_err("cross4k", 2'd3);
`else
        expect_beat("cross4k_b0", 16'h0FFC, 8'hF0, 1'b0, 0);
        expect_beat("cross4k_b1", 16'h1000, 8'hFF, 1'b1, 0);
        expect_idle("cross4k_end");
`endif
        send_cmd(16'h0FFC, 8'd0, 3'd3, INCR);
        expect_beat("len0_b0", 16'h0FFC, 8'hF0, 1'b1, 0);
        expect_idle("len0_end");

        // Reset in the middle of a long burst.
        send_cmd(16'h0100, 8'd7, 3'd3, INCR);
        expect_beat("rb_b0", 16'h0100, 8'hFF, 1'b0, 0);
        expect_beat("rb_b1", 16'h0108, 8'hFF, 1'b0, 0);
        check("rb_b2_valid", 32'(beat_valid), 32'd1);
        check("rb_b2_addr",  32'(beat_addr),  32'h0110);
        areset = 1'b1;
        #1;
        check("rb_async_valid", 32'(beat_valid), 32'd0);
        check("rb_async_ready", 32'(cmd_ready),  32'd0);
        check("rb_async_addr",  32'(beat_addr),  32'd0);
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("rb_release_ready", 32'(cmd_ready), 32'd1);
        @(negedge aclk);
        send_cmd(16'h0200, 8'd1, 3'd3, INCR);
        expect_beat("rb_new_b0", 16'h0200, 8'hFF, 1'b0, 0);
        expect_beat("rb_new_b1", 16'h0208, 8'hFF, 1'b1, 0);
        expect_idle("rb_new_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
